delayed_data_memory: RTL
========================

// Module: delayed_data_memory
// PURPOSE
//  Responder for the MEM pipeline stage's data-memory port: word-addressed data RAM
//  that answers each load/store request after a fixed, parameterised latency.
//  MEM stage holds req_*; busy stalls the pipeline until resp_valid.
//  Read-only debug port exposes rows 0..29 for the end-of-run memory dump.
// PARAMETERS
//  DEPTH_WORDS  512  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1 valid
//  LATENCY      4    cycles from acceptance edge to resp_valid rising edge; legal range 1..255
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  RESET        in   1   asynchronous, active-high reset
//  req_valid    in   1   MEM stage presents a load (req_write=0) or store (req_write=1)
//  req_write    in   1   1 = store (sw), 0 = load (lw)
//  req_addr     in   32  byte address (ALUOut); word index = req_addr[31:2]
//  req_wdata    in   32  store data (WriteData)
//  req_ready    out  1   responder can accept a request this cycle
//  busy         out  1   request in flight; pipeline must freeze
//  resp_valid   out  1   one-cycle pulse: access completed
//  resp_rdata   out  32  load data, valid while resp_valid=1
//  resp_err     out  1   access rejected (misaligned or out of range), qualified by resp_valid
//  dbg_row      in   5   debug word index 0..29
//  dbg_data     out  32  combinational mem[dbg_row]; 0 when dbg_row > 29
// BEHAVIOUR
//  - States: IDLE, BUSY, RESP. req_ready = (state==IDLE); busy = (state!=IDLE).
//  - Accept: rising edge in IDLE with req_valid=1. Latch write/addr/wdata; cnt <= LATENCY-1;
//    state -> BUSY. req_* are ignored in BUSY and RESP.
//  - BUSY: if cnt != 0, cnt <= cnt-1. If cnt == 0, perform the access on this edge, set
//    resp_valid=1, and go to RESP.
//    resp_valid therefore rises exactly LATENCY edges after the acceptance edge.
//  - Access on valid request: store writes mem[word] <= wdata and returns resp_rdata=0.
//    Load sets resp_rdata <= mem[word]. resp_err=0.
//  - Error when addr[1:0] != 0 or addr >= 4*DEPTH_WORDS: no write, resp_rdata=0,
//    resp_err=1. Compare the full 32-bit address; no wrap-around or aliasing.
//  - RESP: resp_valid=1 for exactly this cycle. Next edge -> IDLE and clears resp_valid;
//    resp_rdata and resp_err hold until the next completion.
//    A new request can be accepted only after returning to IDLE.
//  - Throughput: one request per LATENCY+2 cycles.
//  - Store followed by load to the same word: the load returns the new data.
//  - Reset values (async, immediate): state=IDLE, cnt=0, resp_valid=0, resp_rdata=0,
//    resp_err=0. req_ready=1 and busy=0 while RESET=1.
//  - RESET is not a memory clear. RAM contents are zero-initialised at time 0 only and
//    persist across RESET.
//  - RESET in BUSY aborts the request: a pending store is discarded (no write) and no
//    resp_valid is generated. RESET in RESP drops the pulse, but a store has already
//    committed.
//  - Counter width is 8 bits; LATENCY=1 gives BUSY for exactly one cycle (cnt=0).
// TESTING
//  1 Reset: RESET=1 mid-sim -> resp_valid=0, busy=0, req_ready=1 immediately, before any CLK edge.
//  2 Store then load, LATENCY=4: sw 0xDEADBEEF @0x10 accepted at edge k -> resp_valid only
//    at edge k+4, busy high k..k+5. lw @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
//  3 Boundaries, DEPTH=512: lw @0x7FC -> ok. sw @0x800 -> resp_err=1, no write anywhere.
//    lw @0x6 -> resp_err=1, resp_rdata=0. mem[0..1] unchanged.
//  4 Ignore while busy: toggle req_valid/addr/wdata during BUSY -> only the first request
//    executes; exactly one resp_valid pulse.
//  5 Reset mid-operation: sw 0x1234 @0x20, RESET at acceptance+2 -> no resp_valid.
//    A later lw @0x20 returns the prior value (0).
//  6 LATENCY=1 plus debug port: back-to-back sw rows 0..29 with value row*3.
//    Each resp_valid comes 1 edge after acceptance, with 3-cycle spacing.
//    dbg_row=29 -> dbg_data=87; dbg_row=30 -> 0.

Source files
------------

// File: rtl/delayed_data_memory.sv
// delayed_data_memory
//   Word-addressed data RAM that serves the MEM stage's load/store port. Each
//   accepted request completes a fixed LATENCY clock edges after it was
//   accepted. While a request is in flight the pipeline is frozen via busy.
//   A combinational read-only debug port exposes rows 0..29 for memory dumps.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1
//   LATENCY      edges from acceptance to resp_valid (1..255)
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset (does not clear the RAM)
//   req_valid    request present (held by MEM stage)
//   req_write    1 = store, 0 = load
//   req_addr     byte address; word index = req_addr[31:2]
//   req_wdata    store data
//   req_ready    high while idle and able to accept
//   busy         high while a request is in flight
//   resp_valid   one-cycle completion pulse
//   resp_rdata   load data (0 for stores and errors), held until next completion
//   resp_err     misaligned or out-of-range access, held until next completion
//   dbg_row      debug word index
//   dbg_data     mem[dbg_row] for rows 0..29, otherwise 0
module delayed_data_memory #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [4:0]  dbg_row,
  output logic [31:0] dbg_data
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so the byte-address limit never overflows the comparison.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  CNT_LOAD   = 8'(LATENCY - 1);
  localparam logic [4:0]  DBG_ROWS   = 5'd30;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  cnt;
  logic [7:0]  cntNext;
  logic        accept;
  logic        access;

  logic        latWrite;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  logic        addrErr;
  logic [AW-1:0] wordIdx;
  logic [AW-1:0] dbgIdx;

  // Contents start at zero once and are deliberately left alone by RESET.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cntNext   = CNT_LOAD;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          cntNext = cnt - 8'd1;
        end else begin
          access    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

  // ---------------------------------------------------------------------------
  // Request capture and completion datapath
  // ---------------------------------------------------------------------------
  // Requests are captured at acceptance so the MEM stage's later changes to
  // req_* while frozen cannot alter the in-flight access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      latWrite <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else if (accept) begin
      latWrite <= req_write;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
    end
  end

  // Full 32-bit range check: addresses past the array never alias onto it.
  assign addrErr = (latAddr[1:0] != 2'b00) || ({1'b0, latAddr} >= ADDR_LIMIT);
  assign wordIdx = latAddr[AW+1:2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (access) begin
      if (addrErr) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end else begin
        resp_err   <= 1'b0;
        resp_rdata <= latWrite ? '0 : mem[wordIdx];
      end
    end
  end

  // access is only ever raised from BUSY, so an aborting RESET (which forces
  // IDLE) also suppresses the pending store.
  always_ff @(posedge CLK) begin
    if (access && latWrite && !addrErr) begin
      mem[wordIdx] <= latWdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug read port
  // ---------------------------------------------------------------------------
  assign dbgIdx = AW'(dbg_row);

  always_comb begin
    dbg_data = '0;
    if ((dbg_row < DBG_ROWS) && (32'(dbg_row) < DEPTH_WORDS)) begin
      dbg_data = mem[dbgIdx];
    end
  end

endmodule
